mcdf_arbiter: RTL and testbench
===============================

Name: mcdf_arbiter

Overview:
- Sits directly downstream of the three MCDF channel slave FIFOs and upstream of the packet formatter.
- Picks one requesting channel by register-programmed priority and issues a single-cycle ack to that channel's slave FIFO.
- Passes that channel's packet beats (val/data) to the formatter, tagged with the channel id.
- Holds the grant until the latched packet length has been forwarded.

Parameters:
- CH_NUM, 3, number of slave channels (fixed at 3 for this revision; id width 2).
- DATA_W, 32, data beat width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock, asynchronous, active-low
- slv0_req_i, slv1_req_i, slv2_req_i  in  1 each  channel has at least one packet buffered
- slv0_val_i, slv1_val_i, slv2_val_i  in  1 each  channel output beat valid
- slv0_data_i, slv1_data_i, slv2_data_i  in  32 each  channel output beat
- slv0_prio_i, slv1_prio_i, slv2_prio_i  in  2 each  channel priority from register block; 0 = highest
- slv0_pkglen_i, slv1_pkglen_i, slv2_pkglen_i  in  3 each  packet length code; beats = 4 << code
- f2a_id_req_i  in  1  formatter ready to accept a new packet
- a2s0_ack_o, a2s1_ack_o, a2s2_ack_o  out  1 each  one-cycle grant pulse to the channel
- a2f_val_o  out  1  beat valid to formatter
- a2f_data_o  out  32  beat data to formatter
- a2f_id_o  out  2  channel id of current packet
- a2f_pkglen_o  out  6  beat count of current packet

Behaviour:
- Reset values: all acks 0, a2f_val_o 0, a2f_data_o 0, a2f_id_o 0, a2f_pkglen_o 0, FSM IDLE, beat counter 0.
- FSM has three states: IDLE, GRANT, XFER.
- IDLE -> GRANT when f2a_id_req_i=1 and any req=1.
  - Winner is the requester with the numerically lowest prio.
  - Ties go to the lower channel index.
  - At this transition, latch the winner id, winner pkglen beats, and a2f_id_o/a2f_pkglen_o.
- GRANT: the winner's ack is 1 for exactly this one cycle. Next state is XFER unconditionally.
  - Req deassertion during GRANT does not cancel the grant.
- XFER: for each cycle where the granted channel's val=1:
  - Register a2f_val_o=1 and a2f_data_o=granted data (1-cycle latency).
  - Increment the beat counter.
  - When the counter reaches the latched beats on that beat, go to IDLE and clear the counter.
  - Cycles with val=0 hold state; no timeout.
- When the granted val=0, a2f_val_o=0 and a2f_data_o holds its previous value.
- val/data from non-granted channels are ignored at all times.
- pkglen code mapping, 6-bit result: codes 0..3 give 4/8/16/32 beats; codes 4..7 clamp to 32.
- pkglen and prio changes after the IDLE->GRANT transition do not affect the packet in flight.
- No new grant while in GRANT or XFER.
- Earliest re-arbitration is the cycle after the final beat, i.e. IDLE for one cycle minimum.
- a2f_id_o and a2f_pkglen_o hold the last packet's values until the next grant.
- rstn_i low at any point, including mid-XFER, forces all reset values immediately. The partial packet is abandoned; no ack is reissued.

Optional Feature:
- Macro ARB_RR_TIE_EN.
- Defined: ties among equal-priority requesters resolve round-robin. Search starts at the channel after the last granted channel, modulo 3. The last-granted register resets to 2, so the first tie goes to channel 0.
- Undefined: fixed lower-index-wins tie-break; no last-granted register.

Decomposition:
- Shared package mcdf_pkg holds:
  - FSM state enum (IDLE/GRANT/XFER)
  - CH_NUM, DATA_W constants
  - id width 2
  - function pkglen_to_beats(code) returning 6 bits
- One natural sub-module: mcdf_arb_prio_sel, combinational winner select over req/prio, with round-robin pointer input under ARB_RR_TIE_EN.

Test Plan:
- All prio=0, req0=req1=req2=1, f2a_id_req_i=1 (macro off) -> a2s0_ack_o pulses 1 cycle, a2f_id_o=0. With pkglen code 0, 4 beats 0xA0..0xA3 appear on a2f_data_o 1 cycle after slv0_val_i. Return to IDLE, then ch0 is granted again.
- prio0=2, prio1=1, prio2=3, all req -> ch1 granted. pkglen code 2 gives a2f_pkglen_o=16 and exactly 16 a2f_val_o beats.
- Granted ch2 with gaps in slv2_val_i; slv0_val_i toggling with 0xDEAD -> only ch2 data forwarded, counter stalls on gaps, 0xDEAD never appears.
- f2a_id_req_i=0 with req pending -> no ack. Raise f2a_id_req_i -> ack in the following cycle. Change slv1_pkglen_i mid-XFER from 1 to 3 -> packet still ends after 8 beats.
- rstn_i low after beat 3 of 8 -> outputs 0 asynchronously. After release and new req, a fresh grant with a counter starting at 0.
- ARB_RR_TIE_EN defined, all prio equal, all req held -> grant sequence 0,1,2,0. pkglen code 6 -> 32 beats.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared constants, FSM encoding, packet context and length decode for the MCDF arbiter.
package mcdf_pkg;

    localparam int unsigned CH_NUM  = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned PRIO_W  = 2;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned BEATS_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_e;

    // Context of the packet in flight, frozen at grant time.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [BEATS_W-1:0] beats;
    } pkt_ctx_t;

    // Codes above 3 saturate at the largest packet the formatter accepts.
    function automatic logic [BEATS_W-1:0] pkglen_to_beats(input logic [CODE_W-1:0] code);
        logic [BEATS_W-1:0] beats;
        case (code)
            3'd0:    beats = 6'd4;
            3'd1:    beats = 6'd8;
            3'd2:    beats = 6'd16;
            default: beats = 6'd32;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/mcdf_arb_prio_sel.sv
// Combinational winner select: lowest prio value wins; ties by lowest index,
// or round-robin after the last granted channel when ARB_RR_TIE_EN is defined.
module mcdf_arb_prio_sel
    import mcdf_pkg::*;
(
    input  logic [CH_NUM-1:0]             req_i,
    input  logic [CH_NUM-1:0][PRIO_W-1:0] prio_i,
`ifdef ARB_RR_TIE_EN
    input  logic [ID_W-1:0]               rr_last_i,
`endif
    output logic                          win_vld_c_o,
    output logic [ID_W-1:0]               win_id_c_o
);

    logic [PRIO_W-1:0] min_prio;
    logic              found;
`ifdef ARB_RR_TIE_EN
    logic [ID_W-1:0]   idx;
`endif

    always_comb begin
        min_prio    = '1;
        found       = 1'b0;
        win_id_c_o  = '0;
        win_vld_c_o = |req_i;
`ifdef ARB_RR_TIE_EN
        idx         = '0;
`endif
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (req_i[i] && (prio_i[i] < min_prio)) begin
                min_prio = prio_i[i];
            end
        end
`ifdef ARB_RR_TIE_EN
        // Search order begins one past the last granted channel.
        for (int k = 1; k <= int'(CH_NUM); k++) begin
            idx = ID_W'((int'(rr_last_i) + k) % int'(CH_NUM));
            if (!found && req_i[idx] && (prio_i[idx] == min_prio)) begin
                found      = 1'b1;
                win_id_c_o = idx;
            end
        end
`else
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (!found && req_i[i] && (prio_i[i] == min_prio)) begin
                found      = 1'b1;
                win_id_c_o = ID_W'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF channel arbiter: grants one slave FIFO by priority and forwards its packet
// to the formatter. Optional round-robin tie-break under macro ARB_RR_TIE_EN.
module mcdf_arbiter
    import mcdf_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                slv0_req_i,
    input  logic                slv1_req_i,
    input  logic                slv2_req_i,
    input  logic                slv0_val_i,
    input  logic                slv1_val_i,
    input  logic                slv2_val_i,
    input  logic [DATA_W-1:0]   slv0_data_i,
    input  logic [DATA_W-1:0]   slv1_data_i,
    input  logic [DATA_W-1:0]   slv2_data_i,
    input  logic [PRIO_W-1:0]   slv0_prio_i,
    input  logic [PRIO_W-1:0]   slv1_prio_i,
    input  logic [PRIO_W-1:0]   slv2_prio_i,
    input  logic [CODE_W-1:0]   slv0_pkglen_i,
    input  logic [CODE_W-1:0]   slv1_pkglen_i,
    input  logic [CODE_W-1:0]   slv2_pkglen_i,
    input  logic                f2a_id_req_i,
    output logic                a2s0_ack_o,
    output logic                a2s1_ack_o,
    output logic                a2s2_ack_o,
    output logic                a2f_val_o,
    output logic [DATA_W-1:0]   a2f_data_o,
    output logic [ID_W-1:0]     a2f_id_o,
    output logic [BEATS_W-1:0]  a2f_pkglen_o
);

    logic [CH_NUM-1:0]             req_v;
    logic [CH_NUM-1:0]             val_v;
    logic [CH_NUM-1:0][PRIO_W-1:0] prio_v;
    logic [CH_NUM-1:0][CODE_W-1:0] code_v;
    logic [CH_NUM-1:0][DATA_W-1:0] data_v;

    assign req_v  = {slv2_req_i, slv1_req_i, slv0_req_i};
    assign val_v  = {slv2_val_i, slv1_val_i, slv0_val_i};
    assign prio_v = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
    assign code_v = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};
    assign data_v = {slv2_data_i, slv1_data_i, slv0_data_i};

    arb_state_e         state_q, state_d;
    pkt_ctx_t           ctx_q, ctx_d;
    logic [BEATS_W-1:0] cnt_q, cnt_d;
    logic [CH_NUM-1:0]  ack_q, ack_d;
    logic               val_q, val_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               win_vld_c;
    logic [ID_W-1:0]    win_id_c;
    logic               g_val_c;
    logic [DATA_W-1:0]  g_data_c;

`ifdef ARB_RR_TIE_EN
    logic [ID_W-1:0]    rr_last_q, rr_last_d;
`endif

    mcdf_arb_prio_sel u_prio_sel (
        .req_i       (req_v),
        .prio_i      (prio_v),
`ifdef ARB_RR_TIE_EN
        .rr_last_i   (rr_last_q),
`endif
        .win_vld_c_o (win_vld_c),
        .win_id_c_o  (win_id_c)
    );

    // Only the granted channel's beat stream is ever observed.
    assign g_val_c  = val_v[ctx_q.id];
    assign g_data_c = data_v[ctx_q.id];

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        val_d   = 1'b0;
        data_d  = data_q;
`ifdef ARB_RR_TIE_EN
        rr_last_d = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (f2a_id_req_i && win_vld_c) begin
                    state_d         = GRANT;
                    ctx_d.id        = win_id_c;
                    ctx_d.beats     = pkglen_to_beats(code_v[win_id_c]);
                    ack_d[win_id_c] = 1'b1;
`ifdef ARB_RR_TIE_EN
                    rr_last_d       = win_id_c;
`endif
                end
            end
            GRANT: begin
                state_d = XFER;
            end
            XFER: begin
                if (g_val_c) begin
                    val_d  = 1'b1;
                    data_d = g_data_c;
                    if ((cnt_q + 6'd1) == ctx_q.beats) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ctx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            val_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            val_q   <= val_d;
            data_q  <= data_d;
        end
    end

`ifdef ARB_RR_TIE_EN
    // Resets to the last channel so the first tie resolves to channel 0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_last_q <= ID_W'(CH_NUM - 1);
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign a2s0_ack_o   = ack_q[0];
    assign a2s1_ack_o   = ack_q[1];
    assign a2s2_ack_o   = ack_q[2];
    assign a2f_val_o    = val_q;
    assign a2f_data_o   = data_q;
    assign a2f_id_o     = ctx_q.id;
    assign a2f_pkglen_o = ctx_q.beats;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: stimulus pushes expected beats/acks, a negedge monitor checks them.
module tb_mcdf_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [2:0]  req_b;
    logic [2:0]  val_b;
    logic [31:0] data_b [3];
    logic [1:0]  prio_b [3];
    logic [2:0]  code_b [3];
    logic        f2a;
    logic        ack0, ack1, ack2;
    logic        a2f_val;
    logic [31:0] a2f_data;
    logic [1:0]  a2f_id;
    logic [5:0]  a2f_len;

    typedef struct packed {
        logic [1:0]  id;
        logic [5:0]  len;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [2:0] ackq  [$];
    int         total   = 0;
    int         bad     = 0;
    int         ack_cnt = 0;
    logic [2:0] prev_ack = 3'b000;
    bit         noise_en = 1'b0;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .slv0_req_i    (req_b[0]),
        .slv1_req_i    (req_b[1]),
        .slv2_req_i    (req_b[2]),
        .slv0_val_i    (val_b[0]),
        .slv1_val_i    (val_b[1]),
        .slv2_val_i    (val_b[2]),
        .slv0_data_i   (data_b[0]),
        .slv1_data_i   (data_b[1]),
        .slv2_data_i   (data_b[2]),
        .slv0_prio_i   (prio_b[0]),
        .slv1_prio_i   (prio_b[1]),
        .slv2_prio_i   (prio_b[2]),
        .slv0_pkglen_i (code_b[0]),
        .slv1_pkglen_i (code_b[1]),
        .slv2_pkglen_i (code_b[2]),
        .f2a_id_req_i  (f2a),
        .a2s0_ack_o    (ack0),
        .a2s1_ack_o    (ack1),
        .a2s2_ack_o    (ack2),
        .a2f_val_o     (a2f_val),
        .a2f_data_o    (a2f_data),
        .a2f_id_o      (a2f_id),
        .a2f_pkglen_o  (a2f_len)
    );

    // Monitor: every forwarded beat and every ack must match the scoreboard head.
    always @(negedge clk_i) begin
        logic [2:0] acks;
        logic [2:0] ea;
        exp_t       e;
        acks = {ack2, ack1, ack0};
        if (a2f_val) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat: unexpected beat id=%0d len=%0d data=%h", a2f_id, a2f_len, a2f_data);
            end else begin
                e = exp_q.pop_front();
                if (a2f_data !== e.data || a2f_id !== e.id || a2f_len !== e.len) begin
                    bad++;
                    $display("FAIL beat: got id=%0d len=%0d data=%h want id=%0d len=%0d data=%h",
                             a2f_id, a2f_len, a2f_data, e.id, e.len, e.data);
                end
            end
        end
        if (acks != 3'b000) begin
            ack_cnt++;
            total++;
            if (ackq.size() == 0) begin
                bad++;
                $display("FAIL ack: unexpected ack %b", acks);
            end else begin
                ea = ackq.pop_front();
                if (acks !== ea) begin
                    bad++;
                    $display("FAIL ack: got %b want %b", acks, ea);
                end
            end
            total++;
            if (prev_ack !== 3'b000) begin
                bad++;
                $display("FAIL ack_width: ack held %b then %b, want single cycle", prev_ack, acks);
            end
        end
        prev_ack = acks;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (noise_en) begin
            val_b[0]  = ~val_b[0];
            data_b[0] = 32'hDEAD;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input logic [1:0] ch, output bit ok);
        logic [2:0] acks;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            acks = {ack2, ack1, ack0};
            if (acks[ch]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: ch%0d got no ack within 40 cycles", ch);
        end
    endtask

    // Slave model: await ack, stream nb beats, then offer a stray beat that must be dropped.
    task automatic run_pkt(input logic [1:0] ch, input int nb, input logic [31:0] base,
                           input bit gap, input bit last, input bit mod_code);
        bit   ok;
        exp_t e;
        ackq.push_back(3'b001 << ch);
        wait_ack(ch, ok);
        if (!ok) return;
        tick();
        for (int b = 0; b < nb; b++) begin
            val_b[ch]  = 1'b1;
            data_b[ch] = base + 32'(b);
            e.id   = ch;
            e.len  = 6'(nb);
            e.data = base + 32'(b);
            exp_q.push_back(e);
            if (mod_code && b == 2) code_b[ch] = 3'd3;
            tick();
            if (gap && b < nb - 1) begin
                val_b[ch] = 1'b0;
                tick();
            end
        end
        val_b[ch]  = 1'b1;
        data_b[ch] = 32'hBAD0_0000;
        if (last) req_b = 3'b000;
        tick();
        val_b[ch] = 1'b0;
    endtask

    logic [1:0] seq [4];
    int         nbs [4];
    int         snap;
    bit         ok;
    exp_t       e5;

    initial begin
        rstn_i = 1'b0;
        f2a    = 1'b0;
        req_b  = 3'b000;
        val_b  = 3'b000;
        data_b = '{default: 32'd0};
        prio_b = '{default: 2'd0};
        code_b = '{default: 3'd0};
        repeat (3) tick();

        chk("rst_ack",  32'({ack2, ack1, ack0}), 32'd0);
        chk("rst_val",  32'(a2f_val), 32'd0);
        chk("rst_data", a2f_data, 32'd0);
        chk("rst_id",   32'(a2f_id), 32'd0);
        chk("rst_len",  32'(a2f_len), 32'd0);
        rstn_i = 1'b1;
        tick();
        f2a = 1'b1;

        // Equal priorities, all requesting, held across packets.
`ifdef ARB_RR_TIE_EN
        seq = '{2'd0, 2'd1, 2'd2, 2'd0};
        nbs = '{4, 4, 32, 4};
`else
        seq = '{2'd0, 2'd0, 2'd0, 2'd0};
        nbs = '{4, 4, 4, 4};
`endif
        code_b = '{3'd0, 3'd0, 3'd6};
        req_b  = 3'b111;
        for (int p = 0; p < 4; p++) begin
            run_pkt(seq[p], nbs[p], 32'hA0 + 32'(p * 256), 1'b0, p == 3, 1'b0);
        end

        // Distinct priorities: ch1 has the lowest value; code 2 is 16 beats.
        prio_b = '{2'd2, 2'd1, 2'd3};
        code_b = '{3'd0, 3'd2, 3'd0};
        req_b  = 3'b111;
        run_pkt(2'd1, 16, 32'h1000, 1'b0, 1'b1, 1'b0);

        // ch2 with gaps, code 6 clamps to 32; ch0 toggles 0xDEAD unrequested.
        prio_b   = '{default: 2'd0};
        code_b   = '{3'd0, 3'd0, 3'd6};
        req_b    = 3'b100;
        noise_en = 1'b1;
        run_pkt(2'd2, 32, 32'h2000, 1'b1, 1'b1, 1'b0);
        noise_en = 1'b0;
        val_b[0] = 1'b0;

        // Formatter not ready: no ack; once ready, ack next cycle; pkglen change mid-packet ignored.
        f2a    = 1'b0;
        code_b = '{3'd0, 3'd1, 3'd0};
        req_b  = 3'b010;
        snap   = ack_cnt;
        repeat (4) tick();
        chk("noack_fmt_busy", 32'(ack_cnt - snap), 32'd0);
        f2a = 1'b1;
        tick();
        chk("ack_after_fmt_ready", 32'({ack2, ack1, ack0}), 32'b010);
        run_pkt(2'd1, 8, 32'h3000, 1'b0, 1'b1, 1'b1);

        // Reset after beat 3 of 8, then a fresh full packet.
        code_b = '{3'd0, 3'd1, 3'd0};
        req_b  = 3'b010;
        ackq.push_back(3'b010);
        wait_ack(2'd1, ok);
        if (ok) begin
            tick();
            for (int b = 0; b < 3; b++) begin
                val_b[1]  = 1'b1;
                data_b[1] = 32'h4000 + 32'(b);
                e5.id   = 2'd1;
                e5.len  = 6'd8;
                e5.data = 32'h4000 + 32'(b);
                exp_q.push_back(e5);
                tick();
            end
            val_b[1] = 1'b0;
            @(negedge clk_i);
            #1;
            rstn_i = 1'b0;
            req_b  = 3'b000;
            #1;
            chk("async_rst_ack",  32'({ack2, ack1, ack0}), 32'd0);
            chk("async_rst_val",  32'(a2f_val), 32'd0);
            chk("async_rst_data", a2f_data, 32'd0);
            chk("async_rst_id",   32'(a2f_id), 32'd0);
            chk("async_rst_len",  32'(a2f_len), 32'd0);
        end
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
        req_b = 3'b010;
        run_pkt(2'd1, 8, 32'h5000, 1'b0, 1'b1, 1'b0);

        repeat (5) tick();
        chk("beats_all_seen", 32'(exp_q.size()), 32'd0);
        chk("acks_all_seen",  32'(ackq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
